// File: rtl/spwm_gate_controller.sv
// spwm_gate_controller
//   Sequencer and gate-drive stage for a three-phase sine-triangle PWM
//   inverter. It soft-starts the modulation index, inserts dead time on each
//   complementary gate pair and forces all gates low on a fault.
//
//   Optional build macro: SOFT_STOP_EN
//     defined     : stop in RAMP_UP/RUN ramps the modulation index down to 0
//     not defined : stop in RAMP_UP/RUN drops straight to IDLE
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start, stop              level run/stop requests (stop has priority)
//   fault_in, fault_clr      external fault, fault acknowledge
//   pwm_a/b/c                raw comparator outputs
//   mod_index[7:0]           amplitude scale for the sine generator
//   Va/Van, Vb/Vbn, Vc/Vcn   dead-time-protected gate drives
//   state[2:0]               0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN, 4 FAULT
//   running, fault_latched   RUN / FAULT indicators
module spwm_gate_controller #(
  parameter int DEAD_CYCLES = 4,
  parameter int RAMP_DIV    = 256,
  parameter int RAMP_STEP   = 1,
  parameter int MI_MAX      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_in,
  input  logic       fault_clr,
  input  logic       pwm_a,
  input  logic       pwm_b,
  input  logic       pwm_c,
  output logic [7:0] mod_index,
  output logic       Va,
  output logic       Van,
  output logic       Vb,
  output logic       Vbn,
  output logic       Vc,
  output logic       Vcn,
  output logic [2:0] state,
  output logic       running,
  output logic       fault_latched
);

  localparam int                 PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [7:0]         DEAD_LD    = 8'(DEAD_CYCLES);
  localparam logic [7:0]         MI_TOP     = 8'(MI_MAX);
  localparam logic signed [9:0]  STEP_S     = 10'(RAMP_STEP);
  localparam logic signed [9:0]  TOP_S      = 10'(MI_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mod_q, mod_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            fault_q, fault_d;
  logic [2:0]      raw_q, raw_d;
  logic [2:0][7:0] cnt_q, cnt_d;
  logic [2:0]      hi_q, hi_d;
  logic [2:0]      lo_q, lo_d;
  logic            ramp_wrap;
  logic            en_q, en_d;

  // Saturating modulation-index step up, clamped at MI_MAX.
  function automatic logic [7:0] sat_up(input logic [7:0] v);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) + STEP_S;
    return (s > TOP_S) ? MI_TOP : s[7:0];
  endfunction

`ifdef SOFT_STOP_EN
  // Saturating modulation-index step down, clamped at 0.
  function automatic logic [7:0] sat_down(input logic [7:0] v);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) - STEP_S;
    return (s < 10'sd0) ? 8'd0 : s[7:0];
  endfunction
`endif

  function automatic logic gate_en(input state_t s);
    return (s == S_RAMP_UP) || (s == S_RUN) || (s == S_RAMP_DOWN);
  endfunction

  // Sequencer: fault overrides everything, then stop, then start.
  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    presc_d   = presc_q;
    ramp_wrap = (presc_q == PRESC_LAST);
    if (fault_in) begin
      state_d = S_FAULT;
      mod_d   = 8'd0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mod_d   = 8'd0;
          presc_d = '0;
          if (start && !stop) state_d = S_RAMP_UP;
        end
        S_RAMP_UP, S_RUN: begin
          if (stop) begin
            presc_d = '0;
`ifdef SOFT_STOP_EN
            state_d = S_RAMP_DOWN;
`else
            state_d = S_IDLE;
            mod_d   = 8'd0;
`endif
          end else if (state_q == S_RUN) begin
            mod_d = MI_TOP;
          end else if (mod_q == MI_TOP) begin
            state_d = S_RUN;
            presc_d = '0;
          end else if (ramp_wrap) begin
            mod_d   = sat_up(mod_q);
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
`ifdef SOFT_STOP_EN
        S_RAMP_DOWN: begin
          // A fresh start resumes the ramp from wherever the index is now.
          if (start && !stop) begin
            state_d = S_RAMP_UP;
            presc_d = '0;
          end else if (mod_q == 8'd0) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else if (ramp_wrap) begin
            mod_d   = sat_down(mod_q);
            presc_d = '0;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
`endif
        S_FAULT: begin
          mod_d   = 8'd0;
          presc_d = '0;
          if (fault_clr) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          mod_d   = 8'd0;
          presc_d = '0;
        end
      endcase
    end
    running_d = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  // Dead-time insertion. Gate values are taken from the next-state view so
  // a fault or stop blanks the gates on the same edge that changes state.
  always_comb begin
    raw_d = {pwm_c, pwm_b, pwm_a};
    en_q  = gate_en(state_q);
    en_d  = gate_en(state_d);
    cnt_d = cnt_q;
    hi_d  = 3'b000;
    lo_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (!en_d) begin
        cnt_d[i] = DEAD_LD;
      end else begin
        // Entering an enabled state counts as an edge: first drive waits.
        if (!en_q || (raw_d[i] != raw_q[i])) begin
          cnt_d[i] = DEAD_LD;
        end else if (cnt_q[i] != 8'd0) begin
          cnt_d[i] = cnt_q[i] - 8'd1;
        end
        if (cnt_d[i] == 8'd0) begin
          hi_d[i] = raw_d[i];
          lo_d[i] = ~raw_d[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mod_q     <= 8'd0;
      presc_q   <= '0;
      running_q <= 1'b0;
      fault_q   <= 1'b0;
      raw_q     <= 3'b000;
      cnt_q     <= {3{DEAD_LD}};
      hi_q      <= 3'b000;
      lo_q      <= 3'b000;
    end else begin
      state_q   <= state_d;
      mod_q     <= mod_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      fault_q   <= fault_d;
      raw_q     <= raw_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mod_index     = mod_q;
  assign state         = state_q;
  assign running       = running_q;
  assign fault_latched = fault_q;
  assign Va            = hi_q[0];
  assign Van           = lo_q[0];
  assign Vb            = hi_q[1];
  assign Vbn           = lo_q[1];
  assign Vc            = hi_q[2];
  assign Vcn           = lo_q[2];

endmodule

// File: doc/spwm_gate_controller.md
Name: spwm_gate_controller

Overview:
- Sequences the three-phase sine-triangle PWM inverter path.
- Sits between the three comparator outputs and the gate-drive pins.
- Owns start-up and shut-down: soft-start ramps the modulation index fed to the sine generator's amplitude input, then holds it; stop and fault are handled here.
- Inserts dead time on each complementary pair and forces all gates low on fault.

Parameters:
- DEAD_CYCLES, 4, clocks both sides of a phase stay low after a raw PWM edge (0..255)
- RAMP_DIV, 256, clocks between modulation-index steps during ramps (>=1)
- RAMP_STEP, 1, modulation-index increment/decrement per ramp step
- MI_MAX, 255, run-time modulation index (8-bit)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  level request to run, sampled every clock
- stop  in  1  level request to stop, sampled every clock
- fault_in  in  1  external fault (overcurrent/driver fault), active-high
- fault_clr  in  1  fault acknowledge
- pwm_a, pwm_b, pwm_c  in  1 each  raw comparator outputs (sine > triangle)
- mod_index  out  8  amplitude scale to sine generator
- Va, Van, Vb, Vbn, Vc, Vcn  out  1 each  dead-time-protected gate drives
- state  out  3  0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN, 4 FAULT
- running  out  1  high only in RUN
- fault_latched  out  1  high in FAULT

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; mod_index = 0.
  - All six gate outputs = 0; running = 0; fault_latched = 0.
  - Ramp prescaler = 0; per-phase dead counters = DEAD_CYCLES; sampled raw = 0.
- Priority each cycle: rst > fault_in > stop > start.
- All outputs are registered. Transitions take effect at the edge where the condition is sampled.
- IDLE:
  - start=1 -> RAMP_UP; mod_index stays 0; prescaler cleared.
- RAMP_UP:
  - Prescaler counts 0..RAMP_DIV-1.
  - On the wrap, mod_index = min(mod_index+RAMP_STEP, MI_MAX), computed 9-bit and saturated.
  - When mod_index == MI_MAX -> RUN on the next edge.
  - stop=1 -> RAMP_DOWN (see Optional Feature).
- RUN:
  - mod_index held at MI_MAX.
  - stop=1 -> RAMP_DOWN.
  - start is ignored.
- RAMP_DOWN:
  - Same prescaler; mod_index = max(mod_index-RAMP_STEP, 0), saturating.
  - When mod_index == 0 -> IDLE.
  - start=1 with stop=0 -> RAMP_UP, continuing from the current mod_index with the prescaler cleared.
- FAULT:
  - Entered from any state when fault_in=1. Gates are 0 and mod_index is 0 from the entry edge.
  - Exit to IDLE only when fault_clr=1 and fault_in=0 in the same cycle.
  - start and stop are ignored.
  - fault_in asserted while already in FAULT keeps the block in FAULT.
- Gate enable:
  - Gates are enabled in RAMP_UP, RUN and RAMP_DOWN; in IDLE and FAULT all six outputs are 0.
  - On entry to an enabled state, each phase loads DEAD_CYCLES, so the first gate assertion is delayed by the dead time.
- Dead time, per phase x:
  - Raw pwm_x is registered every cycle.
  - If the new sample differs from the previous one, Vx=Vxn=0 and the counter reloads DEAD_CYCLES.
  - Otherwise a nonzero counter decrements.
  - When the counter is 0, Vx = raw and Vxn = ~raw.
  - Timing: a raw edge sampled at edge k gives both outputs 0 after edge k and the new side high after edge k+DEAD_CYCLES.
  - A pulse shorter than DEAD_CYCLES restarts the counter, so both sides stay 0 (the pulse is swallowed).
  - DEAD_CYCLES=0: outputs follow the registered raw with 1-clock latency.
- Invariant: Vx and Vxn are never both 1, in any state, including across reset and fault.
- Mid-ramp reset or fault: mod_index returns to 0 immediately; no partial ramp is retained.

Optional Feature:
- Macro: SOFT_STOP_EN.
- Defined: stop in RAMP_UP or RUN goes to RAMP_DOWN and ramps to 0 as above.
- Not defined:
  - RAMP_DOWN state is absent; state code 3 is never output.
  - stop in RAMP_UP or RUN goes directly to IDLE: gates 0 and mod_index 0 on the next edge.

Test Plan:
- Soft start: reset, start=1 with RAMP_DIV=4, RAMP_STEP=16, MI_MAX=64 -> mod_index 16/32/48/64 at 4-clock spacing; state RUN (2) one edge after 64; running=1.
- Dead time: in RUN, DEAD_CYCLES=4, toggle pwm_a 0->1 -> Va=Van=0 for 4 clocks, then Va=1, Van=0; the reverse edge gives Van=1 after 4 clocks.
- Glitch swallow: 2-clock high pulse on pwm_b with DEAD_CYCLES=4 -> Vb and Vbn stay 0 throughout; no overlap ever.
- Fault: fault_in=1 mid-RAMP_UP -> next edge state=4, all gates 0, mod_index=0, fault_latched=1. fault_clr=1 while fault_in=1 -> stays in FAULT. fault_in=0 with fault_clr=1 -> IDLE.
- Stop, SOFT_STOP_EN defined: stop in RUN -> mod_index 64->48->32->16->0, then IDLE. Not defined: stop -> IDLE next edge with gates 0.
- Restart during ramp-down: start=1 with stop=0 at mod_index=32 -> RAMP_UP from 32, reaching RUN at 64. Simultaneous start and stop -> stop wins.
